// File: rtl/siso_trellis_sched.sv
// siso_trellis_sched
// ------------------
// Step sequencer for one max-log-MAP SISO half-iteration. After an accepted
// start it runs a forward pass over N = K + TAIL trellis steps, then a
// backward pass over the same steps in reverse order.
//
// Forward pass:  the alpha unit is driven through fsm_state_o and
//                valid_branch_o. Branch metrics are fetched and alphas stored.
// Backward pass: branch metrics and alphas are read back in reverse order,
//                and the beta/LLR stage is strobed.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous, active-high reset
//   start_i          start request, sampled only while idle
//   blk_len_i        block length K, sampled with start_i
//   busy_o           high whenever the sequencer is not idle
//   done_o           one-cycle pulse at the end of the backward pass
//   err_o            one-cycle pulse after a start with an illegal K
//   fsm_state_o      alpha unit mode: 00 idle/reset, 01 fwd, 10 bwd, 11 done
//   valid_branch_o   alpha compute strobe
//   bm_rd_en_o       branch-metric RAM read enable (1-cycle latency)
//   bm_rd_addr_o     branch-metric RAM read address
//   alpha_wr_en_o    alpha RAM write enable
//   alpha_wr_addr_o  alpha RAM write address
//   alpha_rd_en_o    alpha RAM read enable (1-cycle latency)
//   alpha_rd_addr_o  alpha RAM read address
//   beta_valid_o     beta compute strobe
//   llr_valid_o      LLR output strobe, data steps only
//
// Every output is decoded from registered state only. No input reaches an
// output combinationally.

module siso_trellis_sched #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned K_MAX  = 6144,
  parameter int unsigned TAIL   = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] blk_len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        fsm_state_o,
  output logic              valid_branch_o,
  output logic              bm_rd_en_o,
  output logic [ADDR_W-1:0] bm_rd_addr_o,
  output logic              alpha_wr_en_o,
  output logic [ADDR_W-1:0] alpha_wr_addr_o,
  output logic              alpha_rd_en_o,
  output logic [ADDR_W-1:0] alpha_rd_addr_o,
  output logic              beta_valid_o,
  output logic              llr_valid_o
);

  localparam logic [ADDR_W-1:0] KMax = ADDR_W'(K_MAX);
  localparam logic [ADDR_W-1:0] Tail = ADDR_W'(TAIL);
  localparam logic [ADDR_W-1:0] One  = ADDR_W'(1);

  // Alpha unit mode codes.
  localparam logic [1:0] ModeIdle = 2'b00;
  localparam logic [1:0] ModeFwd  = 2'b01;
  localparam logic [1:0] ModeBwd  = 2'b10;
  localparam logic [1:0] ModeDone = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StFPre,
    StFA,
    StFB,
    StBPre,
    StBA,
    StBB,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;        // trellis step counter
  logic [ADDR_W-1:0] n_q, n_d;        // total steps, K + TAIL
  logic [ADDR_W-1:0] klen_q, klen_d;  // data steps, K
  logic              err_q, err_d;

  logic              len_ok;
  logic [ADDR_W-1:0] k_m1;
  logic              k_lt_klen;
  logic              k_m1_lt_klen;
  logic              k_lt_n;
  logic              k_is_zero;

  // Shared comparisons on the registered counter.
  always_comb begin
    len_ok       = (blk_len_i != '0) && (blk_len_i <= KMax);
    k_m1         = k_q - One;
    k_lt_klen    = (k_q < klen_q);
    k_m1_lt_klen = (k_m1 < klen_q);
    k_lt_n       = (k_q < n_q);
    k_is_zero    = (k_q == '0);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      k_q     <= '0;
      n_q     <= '0;
      klen_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      klen_q  <= klen_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    klen_d  = klen_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (len_ok) begin
            klen_d  = blk_len_i;
            n_d     = blk_len_i + Tail;
            k_d     = '0;
            state_d = StFPre;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StFPre: state_d = StFA;

      // Alpha for step k is computed here; the counter advances on exit.
      StFA: begin
        k_d     = k_q + One;
        state_d = StFB;
      end

      StFB: begin
        if (k_lt_n) begin
          state_d = StFA;
        end else begin
          // k == N here, so N - 1 is the last trellis step.
          k_d     = n_q - One;
          state_d = StBPre;
        end
      end

      StBPre: state_d = StBA;

      StBA: state_d = StBB;

      StBB: begin
        if (k_is_zero) begin
          state_d = StDone;
        end else begin
          k_d     = k_m1;
          state_d = StBA;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    fsm_state_o     = ModeIdle;
    busy_o          = (state_q != StIdle);
    done_o          = 1'b0;
    err_o           = err_q;
    valid_branch_o  = 1'b0;
    bm_rd_en_o      = 1'b0;
    bm_rd_addr_o    = '0;
    alpha_wr_en_o   = 1'b0;
    alpha_wr_addr_o = '0;
    alpha_rd_en_o   = 1'b0;
    alpha_rd_addr_o = '0;
    beta_valid_o    = 1'b0;
    llr_valid_o     = 1'b0;

    unique case (state_q)
      StIdle: fsm_state_o = ModeIdle;

      // Prefetch the step-0 branch metric ahead of the first F_A.
      StFPre: begin
        fsm_state_o  = ModeFwd;
        bm_rd_en_o   = 1'b1;
        bm_rd_addr_o = '0;
      end

      // Only data steps store alphas; tail alphas are never read back.
      StFA: begin
        fsm_state_o     = ModeFwd;
        valid_branch_o  = 1'b1;
        alpha_wr_en_o   = k_lt_klen;
        alpha_wr_addr_o = k_q;
      end

      // Alpha unit copies its state; fetch the metric for the next step.
      StFB: begin
        fsm_state_o  = ModeFwd;
        bm_rd_en_o   = k_lt_n;
        bm_rd_addr_o = k_q;
      end

      StBPre: begin
        fsm_state_o     = ModeBwd;
        bm_rd_en_o      = 1'b1;
        bm_rd_addr_o    = k_q;
        alpha_rd_en_o   = k_lt_klen;
        alpha_rd_addr_o = k_q;
      end

      StBA: begin
        fsm_state_o  = ModeBwd;
        beta_valid_o = 1'b1;
        llr_valid_o  = k_lt_klen;
      end

      // Prefetch for step k-1; nothing to fetch once step 0 is consumed.
      StBB: begin
        fsm_state_o = ModeBwd;
        if (!k_is_zero) begin
          bm_rd_en_o      = 1'b1;
          bm_rd_addr_o    = k_m1;
          alpha_rd_en_o   = k_m1_lt_klen;
          alpha_rd_addr_o = k_m1;
        end
      end

      StDone: begin
        fsm_state_o = ModeDone;
        done_o      = 1'b1;
      end

      default: fsm_state_o = ModeIdle;
    endcase
  end

endmodule

// File: tb/tb_siso_trellis_sched.sv
// Self-checking bench for siso_trellis_sched. A cycle-timeline reference model
// (position t within a block, block length K) predicts every output per cycle.
module tb_siso_trellis_sched;

  localparam int AW = 13;
  localparam int KM = 6144;
  localparam int TL = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] blk_len;
  logic          busy, done, err, valid_branch;
  logic [1:0]    fsm_state;
  logic          bm_rd_en, alpha_wr_en, alpha_rd_en, beta_valid, llr_valid;
  logic [AW-1:0] bm_rd_addr, alpha_wr_addr, alpha_rd_addr;

  siso_trellis_sched #(
    .ADDR_W (AW),
    .K_MAX  (KM),
    .TAIL   (TL)
  ) u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .blk_len_i       (blk_len),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err),
    .fsm_state_o     (fsm_state),
    .valid_branch_o  (valid_branch),
    .bm_rd_en_o      (bm_rd_en),
    .bm_rd_addr_o    (bm_rd_addr),
    .alpha_wr_en_o   (alpha_wr_en),
    .alpha_wr_addr_o (alpha_wr_addr),
    .alpha_rd_en_o   (alpha_rd_en),
    .alpha_rd_addr_o (alpha_rd_addr),
    .beta_valid_o    (beta_valid),
    .llr_valid_o     (llr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: m_t = 0 when idle, else cycle index since the accepting
  // edge (1 = prefetch ... 4N+3 = done). m_err = error pulse expected now.
  int m_t   = 0;
  int m_k   = 0;
  bit m_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s (t=%0d K=%0d) @%0t: got %0d, expected %0d",
               tag, m_t, m_k, $time, obs, exp_v);
    end
  endtask

  task automatic check_outs();
    int n, j, off, kk;
    int e_fsm, e_bma, e_awa, e_ara;
    bit e_busy, e_done, e_err, e_vb, e_bme, e_awe, e_are, e_beta, e_llr;
    n = m_k + TL;
    e_fsm = 0; e_bma = 0; e_awa = 0; e_ara = 0;
    e_busy = (m_t != 0); e_done = 0; e_err = 0; e_vb = 0; e_bme = 0;
    e_awe = 0; e_are = 0; e_beta = 0; e_llr = 0;
    if (m_t == 0) begin
      e_err = m_err;
    end else if (m_t == 1) begin
      e_fsm = 1; e_bme = 1; e_bma = 0;
    end else if (m_t <= 2 * n + 1) begin
      e_fsm = 1;
      j = (m_t - 2) / 2;
      if ((m_t % 2) == 0) begin
        e_vb = 1; e_awe = (j < m_k); e_awa = j;
      end else begin
        e_bme = (j + 1 < n); e_bma = j + 1;
      end
    end else if (m_t == 2 * n + 2) begin
      e_fsm = 2; e_bme = 1; e_bma = n - 1; e_are = (n - 1 < m_k); e_ara = n - 1;
    end else if (m_t <= 4 * n + 2) begin
      e_fsm = 2;
      off = m_t - (2 * n + 3);
      kk = n - 1 - off / 2;
      if ((off % 2) == 0) begin
        e_beta = 1; e_llr = (kk < m_k);
      end else if (kk > 0) begin
        e_bme = 1; e_bma = kk - 1; e_are = (kk - 1 < m_k); e_ara = kk - 1;
      end
    end else begin
      e_fsm = 3; e_done = 1;
    end
    check_eq("busy", busy, e_busy);
    check_eq("done", done, e_done);
    check_eq("err", err, e_err);
    check_eq("fsm_state", fsm_state, e_fsm);
    check_eq("valid_branch", valid_branch, e_vb);
    check_eq("bm_rd_en", bm_rd_en, e_bme);
    check_eq("bm_rd_addr", bm_rd_addr, e_bma);
    check_eq("alpha_wr_en", alpha_wr_en, e_awe);
    check_eq("alpha_wr_addr", alpha_wr_addr, e_awa);
    check_eq("alpha_rd_en", alpha_rd_en, e_are);
    check_eq("alpha_rd_addr", alpha_rd_addr, e_ara);
    check_eq("beta_valid", beta_valid, e_beta);
    check_eq("llr_valid", llr_valid, e_llr);
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic cycle(input bit st, input int len);
    start   = st;
    blk_len = len[AW-1:0];
    @(posedge clk);
    m_err = 1'b0;
    if (m_t == 0) begin
      if (st) begin
        if (len >= 1 && len <= KM) begin
          m_t = 1;
          m_k = len;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (m_t == 4 * (m_k + TL) + 3) begin
      m_t = 0;
    end else begin
      m_t++;
    end
    @(negedge clk);
    check_outs();
  endtask

  // Start a block and clock it to idle; optionally spray start while busy.
  task automatic run_block(input int len, input bit noise,
                           output int done_cyc, output int max_addr,
                           output int wr_cnt, output int llr_cnt);
    int cyc;
    done_cyc = -1; max_addr = -1; wr_cnt = 0; llr_cnt = 0;
    cycle(1'b1, len);
    cyc = 1;
    while (m_t != 0) begin
      if (done && done_cyc < 0) done_cyc = cyc;
      if (bm_rd_en && int'(bm_rd_addr) > max_addr) max_addr = int'(bm_rd_addr);
      if (alpha_wr_en) wr_cnt++;
      if (llr_valid) llr_cnt++;
      cycle(noise && ($urandom_range(0, 3) == 0), int'($urandom_range(0, 8191)));
      cyc++;
    end
  endtask

  initial begin
    int dc, ma, wc, lc, len;
    rst = 1'b1; start = 1'b0; blk_len = '0;
    repeat (2) @(negedge clk);
    check_outs();
    rst = 1'b0;
    cycle(1'b0, 0);

    // Nominal K = 4.
    run_block(4, 1'b0, dc, ma, wc, lc);
    check_eq("k4_done_cycle", dc, 31);
    check_eq("k4_alpha_writes", wc, 4);
    check_eq("k4_llr_count", lc, 4);

    // Asynchronous reset in the middle of the forward pass.
    cycle(1'b1, 10);
    repeat (4) cycle(1'b0, 0);
    #2 rst = 1'b1;
    #1 m_t = 0; m_err = 1'b0;
    check_outs();
    @(negedge clk);
    check_outs();
    rst = 1'b0;
    run_block(4, 1'b0, dc, ma, wc, lc);
    check_eq("after_rst_done_cycle", dc, 31);

    // K = 1: smallest legal block.
    run_block(1, 1'b0, dc, ma, wc, lc);
    check_eq("k1_done_cycle", dc, 19);
    check_eq("k1_alpha_writes", wc, 1);
    check_eq("k1_llr_count", lc, 1);

    // Illegal lengths: error pulse only.
    cycle(1'b1, 0);
    cycle(1'b0, 0);
    cycle(1'b1, KM + 1);
    cycle(1'b1, 8191);
    cycle(1'b0, 0);

    // Start held high: back-to-back runs with one idle cycle between them.
    repeat (2 * (4 * (3 + TL) + 4) + 5) cycle(1'b1, 3);
    while (m_t != 0) cycle(1'b0, 0);

    // Randomized blocks, gaps, illegal requests and busy-time start noise.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0)
        len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(KM + 1, 8191));
      else
        len = int'($urandom_range(1, 40));
      run_block(len, 1'b1, dc, ma, wc, lc);
      repeat ($urandom_range(0, 3)) cycle(1'b0, 0);
    end

    // Largest block: address ceiling and no counter wrap.
    run_block(KM, 1'b0, dc, ma, wc, lc);
    check_eq("kmax_done_cycle", dc, 24591);
    check_eq("kmax_max_bm_addr", ma, KM + TL - 1);
    cycle(1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
